// File: rtl/line_mem_resp_pkg.sv
// line_mem_resp_pkg: shared line geometry and responder state encoding
package line_mem_resp_pkg;
  localparam int LINE_W = 128;
  localparam int OFF_W  = 4;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/line_mem_resp_bram.sv
// line_mem_resp_bram: single-port line store with synchronous one-cycle read
module line_mem_resp_bram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/line_mem_resp.sv
// line_mem_resp: fixed-latency line-wide memory responder below the cache
module line_mem_resp import line_mem_resp_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = LINE_W,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_r,
  input  logic                  mem_w,
  input  logic [31:0]           mem_addr,
  input  logic [LINE_WIDTH-1:0] mem_w_data,
  output logic [LINE_WIDTH-1:0] mem_r_data,
  output logic                  mem_ready,
  output logic                  busy,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);
  if (LATENCY < 2 || LATENCY > 255) begin : g_bad_latency
    $error("line_mem_resp: LATENCY must be within 2..255");
  end
  if (LINE_WIDTH != LINE_W) begin : g_bad_width
    $error("line_mem_resp: LINE_WIDTH must be 128");
  end
  state_t                  state, nxt;
  logic [7:0]              cnt;
  logic                    op_w, last, we;
  logic [ADDR_WIDTH-1:0]   idx, req_idx, st_addr;
  logic [LINE_WIDTH-1:0]   wdata, dout;
  logic                    unused_addr;
  assign req_idx     = mem_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+OFF_W], mem_addr[OFF_W-1:0]};
  assign busy        = state != IDLE;
  assign last        = state == BUSY && cnt == 8'd1;
  assign we          = last && op_w;
  // Present the incoming index while idle so a LATENCY of 2 still sees fresh dout
  assign st_addr     = state == IDLE ? req_idx : idx;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? ((mem_r | mem_w) ? BUSY : IDLE) :
          state == BUSY ? (cnt == 8'd1 ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      op_w       <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      mem_r_data <= '0;
      mem_ready  <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      state     <= nxt;
      mem_ready <= last;
      if (state == IDLE && (mem_r | mem_w)) begin
        op_w  <= mem_w;
        idx   <= req_idx;
        wdata <= mem_w_data;
        cnt   <= 8'(LATENCY - 1);
      end
      if (state == BUSY) cnt <= cnt - 8'd1;
      if (last && !op_w) mem_r_data <= dout;
      if (state == RESP && op_w) wr_cnt <= wr_cnt + 32'd1;
      if (state == RESP && !op_w) rd_cnt <= rd_cnt + 32'd1;
    end
  end
  line_mem_resp_bram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(LINE_WIDTH)) u_store (
    .clk  (clk),
    .we   (we),
    .addr (st_addr),
    .din  (wdata),
    .dout (dout)
  );
endmodule

// File: tb/tb_line_mem_resp.sv
// tb_line_mem_resp: directed and randomized checks against a line-array model
module tb_line_mem_resp;
  localparam int AW  = 8;
  localparam int LAT = 4;
  logic         clk = 1'b0, rstn = 1'b0, mem_r = 1'b0, mem_w = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic [127:0] mem_w_data = '0;
  logic [127:0] mem_r_data;
  logic         mem_ready, busy;
  logic [31:0]  rd_cnt, wr_cnt;
  line_mem_resp #(.ADDR_WIDTH(AW), .LINE_WIDTH(128), .LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn), .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .mem_ready(mem_ready),
    .busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0;
  logic [127:0] model [int];
  int unsigned  rd_exp = 0, wr_exp = 0;
  logic [127:0] last_rd = '0;
  int           last_ready = 0;
  function automatic int line_of(logic [31:0] a);
    return int'((a / 32'd16) % 32'(1 << AW));
  endfunction
  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(string tag);
    @(negedge clk);
    check({tag, ":busy"}, 128'(busy), 128'd0);
    check({tag, ":ready"}, 128'(mem_ready), 128'd0);
    check({tag, ":rd_cnt"}, 128'(rd_cnt), 128'(rd_exp));
    check({tag, ":wr_cnt"}, 128'(wr_cnt), 128'(wr_exp));
    check({tag, ":rdata"}, mem_r_data, last_rd);
  endtask
  // One transaction: starts in an idle cycle, returns at the negedge of the ready cycle
  task automatic xact(input logic r, input logic w, input logic [31:0] a,
                      input logic [127:0] d, input bit drop, input string tag);
    int k;
    bit got;
    idle_chk(tag);
    mem_r = r; mem_w = w; mem_addr = a; mem_w_data = d;
    k = 0; got = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (drop) begin mem_r = 1'b0; mem_w = 1'b0; end
      got = mem_ready;
      if (!got) check({tag, ":busy_wait"}, 128'(busy), 128'd1);
    end
    check({tag, ":latency"}, 128'(k), 128'(LAT));
    check({tag, ":busy_resp"}, 128'(busy), 128'd1);
    last_ready = cyc;
    if (w) begin
      model[line_of(a)] = d;
      wr_exp++;
    end else begin
      last_rd = model[line_of(a)];
      rd_exp++;
    end
    check({tag, ":rdata_resp"}, mem_r_data, last_rd);
    mem_r = 1'b0; mem_w = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [127:0] p5, old7, p8, a5, d;
    logic [31:0]  a;
    int           w_ready, op;
    p5   = 128'h0123456789ABCDEF0123456789ABCDEF;
    old7 = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
    p8   = 128'h8888_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC;
    a5   = {16{8'hA5}};
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    xact(1'b0, 1'b1, 32'h50, p5, 1'b0, "pre5");
    xact(1'b0, 1'b1, 32'h70, old7, 1'b0, "pre7");
    xact(1'b0, 1'b1, 32'h80, p8, 1'b0, "pre8");
    @(negedge clk);
    rstn = 1'b0;
    rd_exp = 0; wr_exp = 0; last_rd = '0;
    @(negedge clk);
    check("rst:busy", 128'(busy), 128'd0);
    check("rst:ready", 128'(mem_ready), 128'd0);
    check("rst:rd_cnt", 128'(rd_cnt), 128'd0);
    check("rst:wr_cnt", 128'(wr_cnt), 128'd0);
    check("rst:rdata", mem_r_data, 128'd0);
    rstn = 1'b1;
    xact(1'b1, 1'b0, 32'h50, '0, 1'b0, "t1_read");
    xact(1'b0, 1'b1, 32'h3C, a5, 1'b0, "t2_write");
    w_ready = last_ready;
    xact(1'b1, 1'b0, 32'h30, '0, 1'b0, "t2_read");
    check("t2:spacing", 128'(last_ready - w_ready), 128'(LAT + 1));
    xact(1'b0, 1'b1, 32'h00, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0, "t3_wdirty");
    w_ready = last_ready;
    xact(1'b1, 1'b0, 32'h80, '0, 1'b0, "t3_miss");
    check("t3:spacing", 128'(last_ready - w_ready), 128'(LAT + 1));
    xact(1'b1, 1'b1, 32'h10, 128'hB0B0_0000_0000_0000_0000_0000_0000_0B0B, 1'b0, "t4_both");
    xact(1'b1, 1'b0, 32'h10, '0, 1'b0, "t4_read");
    idle_chk("t5_pre");
    mem_w = 1'b1; mem_addr = 32'h70; mem_w_data = ~old7;
    @(negedge clk);
    check("t5:busy", 128'(busy), 128'd1);
    @(negedge clk);
    rstn = 1'b0;
    mem_w = 1'b0;
    rd_exp = 0; wr_exp = 0; last_rd = '0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("t5:no_ready", 128'(mem_ready), 128'd0);
    end
    check("t5:rd_cnt", 128'(rd_cnt), 128'd0);
    check("t5:wr_cnt", 128'(wr_cnt), 128'd0);
    rstn = 1'b1;
    xact(1'b1, 1'b0, 32'h70, '0, 1'b0, "t5_read");
    xact(1'b0, 1'b1, 32'h0000_1004, 128'h6666_AAAA_5555_CCCC_3333_9999_1111_EEEE, 1'b0, "t6_write");
    xact(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, "t6_read");
    xact(1'b1, 1'b0, 32'hFFFF_F00C, '0, 1'b0, "t6_alias");
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      a[11:4] = 8'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      op = $urandom_range(0, 2);
      if (op == 0 && !model.exists(line_of(a))) op = 1;
      xact(op != 1, op != 0, a, d, bit'($urandom_range(0, 1)), "rand");
    end
    idle_chk("end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
